eth_header_extractor: RTL and testbench

- Ingress stage sitting directly upstream of the frame control FSM, on the same accepted-beat stream.
- Counts header bytes per frame and drives the FSM's header_done input during the beat that completes the Ethernet header.
- Captures destination MAC, source MAC, EtherType and optional 802.1Q tag into registers for downstream classification.
- Flags runt frames whose tlast arrives before the header is complete.

---
 rtl/eth_header_extractor.sv | 165 ++++++++++++++++
 tb/tb_eth_header_extractor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eth_header_extractor.sv
// Ethernet header extractor: counts header bytes per frame, signals header completion and captures MAC/EtherType/802.1Q fields.
// Optional macro ETH_HDR_VLAN_EN enables 802.1Q TPID detection (18-byte tagged headers).
module eth_header_extractor #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_accept,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              header_done,
    output logic              hdr_valid,
    output logic              hdr_err,
    output logic [47:0]       dst_mac,
    output logic [47:0]       src_mac,
    output logic [15:0]       ethertype,
    output logic              vlan_present,
    output logic [15:0]       vlan_tci
);

    localparam int BYTES = DATA_W / 8;
`ifdef ETH_HDR_VLAN_EN
    localparam int HDR_MAX = 18;
`else
    localparam int HDR_MAX = 14;
`endif

    typedef enum logic {
        S_HDR  = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  hdr_q [HDR_MAX];
    logic [7:0]  hdr_d [HDR_MAX];
    logic        hdr_valid_q, hdr_valid_d;
    logic        hdr_err_q, hdr_err_d;
    logic [47:0] dst_mac_q, dst_mac_d;
    logic [47:0] src_mac_q, src_mac_d;
    logic [15:0] ethertype_q, ethertype_d;
    logic        vlan_present_q, vlan_present_d;
    logic [15:0] vlan_tci_q, vlan_tci_d;
    logic [5:0]  cnt_end_s;
    logic [5:0]  hdr_len_s;
    logic        tagged_s;

    // Merge current beat lanes over stored header bytes so TPID and fields see same-beat data.
    always_comb begin
        for (int j = 0; j < HDR_MAX; j++) begin
            if (beat_accept && (state_q == S_HDR) &&
                (j >= int'(byte_cnt_q)) && (j < int'(byte_cnt_q) + BYTES)) begin
                hdr_d[j] = s_tdata[8*(j - int'(byte_cnt_q)) +: 8];
            end else begin
                hdr_d[j] = hdr_q[j];
            end
        end
    end

    // Header length selection and field extraction from the merged header view.
    always_comb begin
        cnt_end_s = {1'b0, byte_cnt_q} + 6'(BYTES);
        dst_mac_d = {hdr_d[0], hdr_d[1], hdr_d[2], hdr_d[3], hdr_d[4], hdr_d[5]};
        src_mac_d = {hdr_d[6], hdr_d[7], hdr_d[8], hdr_d[9], hdr_d[10], hdr_d[11]};
`ifdef ETH_HDR_VLAN_EN
        tagged_s = (hdr_d[12] == 8'h81) && (hdr_d[13] == 8'h00);
        if (tagged_s) begin
            hdr_len_s      = 6'd18;
            ethertype_d    = {hdr_d[16], hdr_d[17]};
            vlan_present_d = 1'b1;
            vlan_tci_d     = {hdr_d[14], hdr_d[15]};
        end else begin
            hdr_len_s      = 6'd14;
            ethertype_d    = {hdr_d[12], hdr_d[13]};
            vlan_present_d = 1'b0;
            vlan_tci_d     = 16'h0000;
        end
`else
        tagged_s       = 1'b0;
        hdr_len_s      = 6'd14;
        ethertype_d    = {hdr_d[12], hdr_d[13]};
        vlan_present_d = tagged_s;
        vlan_tci_d     = 16'h0000;
`endif
        header_done = beat_accept && (state_q == S_HDR) && (cnt_end_s >= hdr_len_s);
    end

    // Frame FSM next-state, byte counter and pulse generation.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        hdr_valid_d = 1'b0;
        hdr_err_d   = 1'b0;
        case (state_q)
            S_HDR: begin
                if (header_done) begin
                    byte_cnt_d  = 5'd0;
                    hdr_valid_d = 1'b1;
                    state_d     = s_tlast ? S_HDR : S_BODY;
                end else if (beat_accept && s_tlast) begin
                    byte_cnt_d = 5'd0;
                    hdr_err_d  = 1'b1;
                end else if (beat_accept) begin
                    byte_cnt_d = byte_cnt_q + 5'(BYTES);
                end else begin
                    byte_cnt_d = byte_cnt_q;
                end
            end
            S_BODY: begin
                if (beat_accept && s_tlast) begin
                    state_d    = S_HDR;
                    byte_cnt_d = 5'd0;
                end else begin
                    state_d = S_BODY;
                end
            end
            default: begin
                state_d    = S_HDR;
                byte_cnt_d = 5'd0;
            end
        endcase
    end

    // State, header byte store, pulses and field registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_HDR;
            byte_cnt_q     <= 5'd0;
            hdr_valid_q    <= 1'b0;
            hdr_err_q      <= 1'b0;
            dst_mac_q      <= 48'h0;
            src_mac_q      <= 48'h0;
            ethertype_q    <= 16'h0;
            vlan_present_q <= 1'b0;
            vlan_tci_q     <= 16'h0;
            for (int j = 0; j < HDR_MAX; j++) begin
                hdr_q[j] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_err_q   <= hdr_err_d;
            for (int j = 0; j < HDR_MAX; j++) begin
                hdr_q[j] <= hdr_d[j];
            end
            if (hdr_valid_d) begin
                dst_mac_q      <= dst_mac_d;
                src_mac_q      <= src_mac_d;
                ethertype_q    <= ethertype_d;
                vlan_present_q <= vlan_present_d;
                vlan_tci_q     <= vlan_tci_d;
            end
        end
    end

    assign hdr_valid    = hdr_valid_q;
    assign hdr_err      = hdr_err_q;
    assign dst_mac      = dst_mac_q;
    assign src_mac      = src_mac_q;
    assign ethertype    = ethertype_q;
    assign vlan_present = vlan_present_q;
    assign vlan_tci     = vlan_tci_q;

endmodule

// File: tb/tb_eth_header_extractor.sv
// Directed self-checking bench for eth_header_extractor (DATA_W = 64); tagged-frame expectations follow ETH_HDR_VLAN_EN.
module tb_eth_header_extractor;

    logic        clk;
    logic        rst;
    logic        beat_accept;
    logic [63:0] s_tdata;
    logic        s_tlast;
    logic        header_done;
    logic        hdr_valid;
    logic        hdr_err;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_present;
    logic [15:0] vlan_tci;

    int checks = 0;
    int errors = 0;

    eth_header_extractor #(.DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .beat_accept  (beat_accept),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .header_done  (header_done),
        .hdr_valid    (hdr_valid),
        .hdr_err      (hdr_err),
        .dst_mac      (dst_mac),
        .src_mac      (src_mac),
        .ethertype    (ethertype),
        .vlan_present (vlan_present),
        .vlan_tci     (vlan_tci)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one accepted beat at negedge, check header_done before the edge and pulses after it.
    task automatic beat(input string tag, input logic [63:0] d, input logic last,
                        input logic exp_hd, input logic exp_v, input logic exp_e);
        @(negedge clk);
        beat_accept = 1'b1;
        s_tdata     = d;
        s_tlast     = last;
        #1;
        check({tag, ".header_done"}, 64'(header_done), 64'(exp_hd));
        @(posedge clk);
        #1;
        check({tag, ".hdr_valid"}, 64'(hdr_valid), 64'(exp_v));
        check({tag, ".hdr_err"}, 64'(hdr_err), 64'(exp_e));
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        beat_accept = 1'b0;
        s_tlast     = 1'b0;
        s_tdata     = 64'h0;
        @(posedge clk);
        #1;
        check({tag, ".idle_valid"}, 64'(hdr_valid), 64'd0);
        check({tag, ".idle_err"}, 64'(hdr_err), 64'd0);
    endtask

    task automatic fields(input string tag, input logic [47:0] d, input logic [47:0] s,
                          input logic [15:0] et, input logic vp, input logic [15:0] tci);
        check({tag, ".dst_mac"}, 64'(dst_mac), 64'(d));
        check({tag, ".src_mac"}, 64'(src_mac), 64'(s));
        check({tag, ".ethertype"}, 64'(ethertype), 64'(et));
        check({tag, ".vlan_present"}, 64'(vlan_present), 64'(vp));
        check({tag, ".vlan_tci"}, 64'(vlan_tci), 64'(tci));
    endtask

    localparam logic [63:0] U_B0 = 64'h7766554433221100;
    localparam logic [63:0] U_B1 = 64'h00450008BBAA9988;
    localparam logic [63:0] T_B1 = 64'h64000081BBAA9988;
    localparam logic [63:0] T_B2 = 64'h000000000000DD86;
    localparam logic [63:0] F_B0 = 64'h8070605040302010;
    localparam logic [63:0] F_B1 = 64'h0000DD86C0B0A090;

    initial begin
        rst         = 1'b1;
        beat_accept = 1'b1;
        s_tlast     = 1'b1;
        s_tdata     = 64'hFFFFFFFFFFFFFFFF;

        // Scenario 1: reset held with beat_accept high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.header_done", 64'(header_done), 64'd0);
            check("rst.hdr_valid", 64'(hdr_valid), 64'd0);
            check("rst.hdr_err", 64'(hdr_err), 64'd0);
            fields("rst", 48'h0, 48'h0, 16'h0, 1'b0, 16'h0);
        end
        beat_accept = 1'b0;
        s_tlast     = 1'b0;
        s_tdata     = 64'h0;
        rst         = 1'b0;
        idle("rst_rel");

        // Scenario 2: untagged frame
        beat("untag.b0", U_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("untag.b1", U_B1, 1'b0, 1'b1, 1'b1, 1'b0);
        fields("untag", 48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0000);
        beat("untag.b2", 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("untag");
        fields("untag_hold", 48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0000);

        // Scenario 3: tagged frame
        beat("tag.b0", U_B0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ETH_HDR_VLAN_EN
        beat("tag.b1", T_B1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("tag.b2", T_B2, 1'b0, 1'b1, 1'b1, 1'b0);
        fields("tag", 48'h001122334455, 48'h66778899AABB, 16'h86DD, 1'b1, 16'h0064);
`else
        beat("tag.b1", T_B1, 1'b0, 1'b1, 1'b1, 1'b0);
        beat("tag.b2", T_B2, 1'b0, 1'b0, 1'b0, 1'b0);
        fields("tag", 48'h001122334455, 48'h66778899AABB, 16'h8100, 1'b0, 16'h0000);
`endif
        beat("tag.b3", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("tag");

        // Scenario 4: runt then untagged frame immediately after
        beat("runt.b0", F_B0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef ETH_HDR_VLAN_EN
        fields("runt_hold", 48'h001122334455, 48'h66778899AABB, 16'h86DD, 1'b1, 16'h0064);
`else
        fields("runt_hold", 48'h001122334455, 48'h66778899AABB, 16'h8100, 1'b0, 16'h0000);
`endif
        beat("post_runt.b0", U_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("post_runt.b1", U_B1, 1'b0, 1'b1, 1'b1, 1'b0);
        fields("post_runt", 48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0000);
        beat("post_runt.b2", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Scenario 5: back-to-back, first frame ends on its header beat
        beat("b2b1.b0", U_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("b2b1.b1", U_B1, 1'b1, 1'b1, 1'b1, 1'b0);
        fields("b2b1", 48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0000);
        beat("b2b2.b0", F_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("b2b2.b1", F_B1, 1'b0, 1'b1, 1'b1, 1'b0);
        fields("b2b2", 48'h102030405060, 48'h708090A0B0C0, 16'h86DD, 1'b0, 16'h0000);
        beat("b2b2.b2", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("b2b");

        // Scenario 6: reset mid-frame, then a fresh untagged frame
        beat("mid.b0", F_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        beat_accept = 1'b0;
        rst         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst.hdr_valid", 64'(hdr_valid), 64'd0);
            check("mid_rst.hdr_err", 64'(hdr_err), 64'd0);
        end
        fields("mid_rst", 48'h0, 48'h0, 16'h0, 1'b0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        beat("mid.n0", U_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("mid.n1", U_B1, 1'b0, 1'b1, 1'b1, 1'b0);
        fields("mid_new", 48'h001122334455, 48'h66778899AABB, 16'h0800, 1'b0, 16'h0000);
        beat("mid.n2", 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
